// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES round sequencer.
// Optional round_ack handshake is enabled by defining AES_ROUND_STALL_EN.
package aes_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  localparam logic [1:0] AES_MODE_ENC  = 2'b10;
  localparam logic [1:0] AES_MODE_DEC  = 2'b01;
  localparam logic [1:0] AES_MODE_IDLE = 2'b00;

  localparam int unsigned AES128_NR = 10;
  localparam int unsigned AES192_NR = 12;
  localparam int unsigned AES256_NR = 14;

  localparam int unsigned RIDX_W = 4;

  // Only the two one-hot codes start an operation; 00 and 11 stall.
  function automatic logic mode_is_valid(input logic [1:0] code);
    return (code == AES_MODE_ENC) || (code == AES_MODE_DEC);
  endfunction

endpackage

// File: rtl/aes_round_sequencer_if.sv
// Block-in/block-out handshake plus round-datapath bus of the AES round sequencer.
// round_ack exists only when AES_ROUND_STALL_EN is defined.
interface aes_round_sequencer_if #(
  parameter int unsigned DW = 128
);
  import aes_seq_pkg::*;

  logic [1:0]        ENCRYPT;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     data_in;
  logic [DW-1:0]     round_state;
  logic [RIDX_W-1:0] round_idx;
  logic              round_en;
  logic              round_first;
  logic              round_last;
  logic              mode_enc;
  logic [DW-1:0]     round_result;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     data_out;
  logic              busy;
`ifdef AES_ROUND_STALL_EN
  logic              round_ack;

  modport slave (
    input  ENCRYPT, in_valid, data_in, round_result, out_ready, round_ack,
    output in_ready, round_state, round_idx, round_en, round_first, round_last,
           mode_enc, out_valid, data_out, busy
  );

  modport master (
    output ENCRYPT, in_valid, data_in, round_result, out_ready, round_ack,
    input  in_ready, round_state, round_idx, round_en, round_first, round_last,
           mode_enc, out_valid, data_out, busy
  );
`else
  modport slave (
    input  ENCRYPT, in_valid, data_in, round_result, out_ready,
    output in_ready, round_state, round_idx, round_en, round_first, round_last,
           mode_enc, out_valid, data_out, busy
  );

  modport master (
    output ENCRYPT, in_valid, data_in, round_result, out_ready,
    input  in_ready, round_state, round_idx, round_en, round_first, round_last,
           mode_enc, out_valid, data_out, busy
  );
`endif

endinterface

// File: rtl/aes_round_counter.sv
// Up/down round-key index counter bounded to 0..NR, with direction latched on load.
module aes_round_counter
  import aes_seq_pkg::*;
#(
  parameter int unsigned NR = AES128_NR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              load_up,
  input  logic              step,
  output logic [RIDX_W-1:0] cnt,
  output logic              first_c,
  output logic              last_c
);

  logic up_q;

  // Stepping is suppressed at the terminal value so the index never leaves 0..NR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      up_q <= 1'b0;
    end else if (load) begin
      cnt  <= load_up ? '0 : RIDX_W'(NR);
      up_q <= load_up;
    end else if (step && !last_c) begin
      cnt  <= up_q ? cnt + RIDX_W'(1) : cnt - RIDX_W'(1);
    end
  end

  assign first_c = up_q ? (cnt == '0) : (cnt == RIDX_W'(NR));
  assign last_c  = up_q ? (cnt == RIDX_W'(NR)) : (cnt == '0);

endmodule

// File: rtl/aes_round_sequencer.sv
// Steps an external single-round AES datapath through AddRoundKey plus NR rounds.
// Define AES_ROUND_STALL_EN to let the datapath stretch rounds via round_ack.
module aes_round_sequencer
  import aes_seq_pkg::*;
#(
  parameter int unsigned NR = AES128_NR,
  parameter int unsigned DW = 128
) (
  input  logic clk,
  input  logic rst_n,
  aes_round_sequencer_if.slave bus
);

  seq_state_e        state_q, state_d;
  logic [DW-1:0]     data_q;
  logic              mode_q;
  logic              cnt_load, cnt_step;
  logic              adv_c, in_ready_c, round_en_c;
  logic              first_c, last_c;
  logic [RIDX_W-1:0] cnt;

`ifdef AES_ROUND_STALL_EN
  assign adv_c = bus.round_ack;
`else
  assign adv_c = 1'b1;
`endif

  aes_round_counter #(.NR(NR)) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .load_up (bus.ENCRYPT[1]),
    .step    (cnt_step),
    .cnt     (cnt),
    .first_c (first_c),
    .last_c  (last_c)
  );

  assign in_ready_c = rst_n && (state_q == IDLE) && mode_is_valid(bus.ENCRYPT);
  assign round_en_c = (state_q == INIT) || (state_q == ROUND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready_c) begin
          cnt_load = 1'b1;
          state_d  = INIT;
        end
      end
      INIT: begin
        if (adv_c) begin
          cnt_step = 1'b1;
          state_d  = ROUND;
        end
      end
      ROUND: begin
        if (adv_c) begin
          cnt_step = 1'b1;
          if (last_c) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Block state: loaded on acceptance, replaced by the datapath on each completed round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      mode_q <= 1'b0;
    end else if (cnt_load) begin
      data_q <= bus.data_in;
      mode_q <= bus.ENCRYPT[1];
    end else if (round_en_c && adv_c) begin
      data_q <= bus.round_result;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.round_state = data_q;
  assign bus.round_idx   = cnt;
  assign bus.round_en    = round_en_c;
  assign bus.round_first = (state_q == INIT) && first_c;
  assign bus.round_last  = (state_q == ROUND) && last_c;
  assign bus.mode_enc    = mode_q;
  assign bus.out_valid   = (state_q == DONE);
  assign bus.data_out    = data_q;
  assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer with an XOR-per-round datapath model.
module tb_aes_round_sequencer;
  import aes_seq_pkg::*;

  localparam int unsigned NR = 10;
  localparam int unsigned DW = 128;
  localparam logic [127:0] BLK_B  = {16{8'h0B}};
  localparam logic [127:0] PAT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] PAT_X  = 128'h0b1a29384f5e6d7c8392a1b0c7d6e5f4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_round_sequencer_if #(.DW(DW)) ifc ();

  aes_round_sequencer #(.NR(NR), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // Datapath model: each round XORs every byte with the round index.
  assign ifc.round_result = ifc.round_state ^ {16{4'h0, ifc.round_idx}};

  logic adv;
`ifdef AES_ROUND_STALL_EN
  assign adv = ifc.round_ack;
`else
  assign adv = 1'b1;
`endif

  typedef struct {
    logic [3:0] idx;
    logic       first;
    logic       last;
  } rnd_t;

  typedef struct {
    logic [127:0] data;
    logic         mode;
  } out_t;

  rnd_t rq[$];
  out_t oq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every completed round and every output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.round_en && adv) begin
        check("round_expected", 128'(rq.size() != 0), 128'(1));
        if (rq.size() != 0) begin
          rnd_t r;
          r = rq.pop_front();
          check("round_idx",   128'(ifc.round_idx),   128'(r.idx));
          check("round_first", 128'(ifc.round_first), 128'(r.first));
          check("round_last",  128'(ifc.round_last),  128'(r.last));
        end
      end
      if (ifc.out_valid && ifc.out_ready) begin
        check("out_expected", 128'(oq.size() != 0), 128'(1));
        if (oq.size() != 0) begin
          out_t o;
          o = oq.pop_front();
          check("data_out", ifc.data_out, o.data);
          check("mode_enc", 128'(ifc.mode_enc), 128'(o.mode));
        end
      end
    end
  end

  task automatic push_expect(input logic [1:0] code, input logic [127:0] dout);
    for (int k = 0; k <= int'(NR); k++) begin
      rnd_t r;
      r.idx   = (code == AES_MODE_ENC) ? 4'(k) : 4'(int'(NR) - k);
      r.first = (k == 0);
      r.last  = (k == int'(NR));
      rq.push_back(r);
    end
    oq.push_back('{data: dout, mode: code[1]});
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after the output handshake.
  task automatic run_block(input logic [1:0] code, input logic [127:0] din,
                           input logic [127:0] dout, input logic [1:0] mid_code,
                           input int bp, input bit stall);
    int cyc;
    logic [127:0] held;
    push_expect(code, dout);
    ifc.ENCRYPT   = code;
    ifc.data_in   = din;
    ifc.in_valid  = 1'b1;
    ifc.out_ready = 1'b0;
    #1;
    check("in_ready_idle", 128'(ifc.in_ready), 128'(1));
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    ifc.ENCRYPT  = mid_code;
    ifc.data_in  = '1;
    check("busy_running", 128'(ifc.busy), 128'(1));
    cyc = 1;
    while (!ifc.out_valid && cyc < 60) begin
`ifdef AES_ROUND_STALL_EN
      if (stall && ifc.round_en && ifc.round_idx == 4'd4) begin
        held = ifc.round_state;
        ifc.round_ack = 1'b0;
        repeat (3) begin
          @(posedge clk); #1;
          cyc++;
          check("stall_idx",   128'(ifc.round_idx), 128'(4));
          check("stall_state", ifc.round_state, held);
        end
        ifc.round_ack = 1'b1;
        stall = 1'b0;
      end
`endif
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", 128'(cyc), 128'(int'(NR) + 2 + ((stall || cyc > int'(NR) + 2) ? 3 : 0)));
    held = ifc.data_out;
    repeat (bp) begin
      check("bp_out_valid", 128'(ifc.out_valid), 128'(1));
      check("bp_data_stable", ifc.data_out, dout);
      check("bp_in_ready", 128'(ifc.in_ready), 128'(0));
      @(posedge clk); #1;
    end
    ifc.out_ready = 1'b1;
    #1;
    check("no_same_cycle_turnaround", 128'(ifc.in_ready), 128'(0));
    @(posedge clk); #1;
    ifc.out_ready = 1'b0;
    check("out_valid_cleared", 128'(ifc.out_valid), 128'(0));
    check("busy_cleared", 128'(ifc.busy), 128'(0));
    check("in_ready_after", 128'(ifc.in_ready), 128'(mode_is_valid(mid_code)));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    ifc.ENCRYPT   = AES_MODE_ENC;
    ifc.in_valid  = 1'b0;
    ifc.data_in   = '0;
    ifc.out_ready = 1'b0;
`ifdef AES_ROUND_STALL_EN
    ifc.round_ack = 1'b1;
`endif
    #2;
    check("rst_in_ready",  128'(ifc.in_ready),  128'(0));
    check("rst_busy",      128'(ifc.busy),      128'(0));
    check("rst_out_valid", 128'(ifc.out_valid), 128'(0));
    check("rst_round_en",  128'(ifc.round_en),  128'(0));
    check("rst_data_out",  ifc.data_out,        128'(0));
    check("rst_mode_enc",  128'(ifc.mode_enc),  128'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    run_block(AES_MODE_ENC, 128'(0), BLK_B, AES_MODE_ENC, 0, 1'b0);
    run_block(AES_MODE_DEC, BLK_B, 128'(0), AES_MODE_DEC, 0, 1'b0);

    // Codes 00 and 11 must never start an operation.
    for (int c = 0; c < 4; c += 3) begin
      ifc.ENCRYPT  = 2'(c);
      ifc.in_valid = 1'b1;
      repeat (5) begin
        #1;
        check("gate_in_ready", 128'(ifc.in_ready), 128'(0));
        check("gate_busy",     128'(ifc.busy),     128'(0));
        check("gate_round_en", 128'(ifc.round_en), 128'(0));
        @(posedge clk); #1;
      end
    end
    ifc.in_valid = 1'b0;

    run_block(AES_MODE_ENC, PAT, PAT_X, AES_MODE_DEC, 4, 1'b0);
    run_block(AES_MODE_DEC, PAT_X, PAT, AES_MODE_IDLE, 1, 1'b0);

    // Abort during round 5 of an encrypt.
    push_expect(AES_MODE_ENC, BLK_B);
    ifc.ENCRYPT  = AES_MODE_ENC;
    ifc.data_in  = '0;
    ifc.in_valid = 1'b1;
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    n = 0;
    while (!(ifc.round_en && ifc.round_idx == 4'd5) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_idx5", 128'(ifc.round_idx), 128'(5));
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("abort_round_en",  128'(ifc.round_en),  128'(0));
    check("abort_busy",      128'(ifc.busy),      128'(0));
    check("abort_out_valid", 128'(ifc.out_valid), 128'(0));
    check("abort_data_out",  ifc.data_out,        128'(0));
    check("abort_in_ready",  128'(ifc.in_ready),  128'(0));
    rq.delete();
    oq.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    run_block(AES_MODE_ENC, 128'(0), BLK_B, AES_MODE_ENC, 0, 1'b0);

`ifdef AES_ROUND_STALL_EN
    run_block(AES_MODE_ENC, 128'(0), BLK_B, AES_MODE_ENC, 0, 1'b1);
`endif

    repeat (2) @(posedge clk);
    check("round_queue_drained", 128'(rq.size()), 128'(0));
    check("out_queue_drained",   128'(oq.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
